// File: rtl/fp_pkg.sv
// Shared FSM state type, default field widths and exponent constants for the
// floating-point round/pack datapath.
package fp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } fp_state_t;

  localparam int FP_WIDTH     = 32;
  localparam int FP_EXPO_BITS = 8;
  localparam int FP_MANT_BITS = 23;

  function automatic int exp_bias(input int e);
    return (1 << (e - 1)) - 1;
  endfunction

  function automatic int exp_all_ones(input int e);
    return (1 << e) - 1;
  endfunction

  localparam int FP_BIAS     = exp_bias(FP_EXPO_BITS);
  localparam int FP_EXP_ONES = exp_all_ones(FP_EXPO_BITS);

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even decision on a stored mantissa field; carry flags an
// overflow of the field into the hidden-bit position.
module fp_round_rne
  import fp_pkg::*;
#(
  parameter int mant_bits = FP_MANT_BITS
) (
  input  logic [mant_bits-1:0] frac,
  input  logic                 guard,
  input  logic                 sticky,
  output logic [mant_bits-1:0] frac_out,
  output logic                 carry
);

  logic               round_up;
  logic [mant_bits:0] sum;

  // Ties (guard set, nothing below) only round up when the lsb is odd.
  always_comb begin
    round_up = guard & (frac[0] | sticky);
    sum      = {1'b0, frac} + {{mant_bits{1'b0}}, round_up};
    frac_out = sum[mant_bits-1:0];
    carry    = sum[mant_bits];
  end

endmodule

// File: rtl/fp_round_pack.sv
// Normalise, round (RNE) and pack a raw multiplier product into an IEEE word.
// Define FP_SUBNORMAL_EN to produce subnormals instead of flushing to zero.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int X         = FP_WIDTH,
  parameter int expo_bits = FP_EXPO_BITS,
  parameter int mant_bits = FP_MANT_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [expo_bits+1:0]   in_exp,
  input  logic [2*mant_bits+1:0] in_mant,
  input  logic                   in_special,
  input  logic [X-1:0]           in_special_val,
  output logic [X-1:0]           out,
  output logic                   done,
  input  logic                   out_ready
);

  localparam int EW = expo_bits + 2;
  localparam int MW = 2 * mant_bits + 2;
  localparam int CW = $clog2(MW) + 1;
  localparam logic [CW-1:0]        STEP_LIMIT = CW'(2 * mant_bits + 1);
  localparam logic signed [EW-1:0] EXP_ONE    = EW'(1);
  localparam logic signed [EW-1:0] EXP_MAX    = EW'(exp_all_ones(expo_bits));

  function automatic logic [X-1:0] pack(input logic s,
                                        input logic [expo_bits-1:0] e,
                                        input logic [mant_bits-1:0] f);
    return X'({s, e, f});
  endfunction

  fp_state_t             state_q, state_d;
  logic                  sign_q, sign_d;
  logic signed [EW-1:0]  exp_q, exp_d;
  logic [MW-1:0]         mant_q, mant_d;
  logic                  sticky_q, sticky_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [X-1:0]          out_q, out_d;

  logic                  need_right;
  logic                  flush;
  logic                  sticky_bit;
  logic [mant_bits-1:0]  rne_frac;
  logic                  rne_carry;
  logic                  lead_r;
  logic signed [EW-1:0]  exp_r;

`ifdef FP_SUBNORMAL_EN
  // Below the normal range, denormalise rightwards until the exponent is 1.
  assign need_right = mant_q[MW-1] | (exp_q < EXP_ONE);
  assign flush      = 1'b0;
`else
  assign need_right = mant_q[MW-1];
  assign flush      = (exp_q < EXP_ONE) | ((exp_q == EXP_ONE) & ~mant_q[2*mant_bits]);
`endif

  assign sticky_bit = (|mant_q[mant_bits-2:0]) | sticky_q;

  fp_round_rne #(
    .mant_bits(mant_bits)
  ) u_rne (
    .frac     (mant_q[2*mant_bits-1:mant_bits]),
    .guard    (mant_q[mant_bits-1]),
    .sticky   (sticky_bit),
    .frac_out (rne_frac),
    .carry    (rne_carry)
  );

  // A carry into a subnormal promotes it to exponent 1, which exp_q already is.
  assign lead_r = mant_q[2*mant_bits] | rne_carry;
  assign exp_r  = (rne_carry & mant_q[2*mant_bits]) ? exp_q + EXP_ONE : exp_q;

  // Next-state and datapath updates for every FSM state.
  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d   = in_sign;
          exp_d    = $signed(in_exp);
          mant_d   = in_mant;
          sticky_d = 1'b0;
          cnt_d    = '0;
          if (in_special) begin
            out_d   = in_special_val;
            state_d = ST_DONE;
          end else if (in_mant == '0) begin
            out_d   = pack(in_sign, '0, '0);
            state_d = ST_DONE;
          end else begin
            state_d = ST_NORM;
          end
        end
      end
      ST_NORM: begin
        if ((cnt_q != STEP_LIMIT) && need_right) begin
          mant_d   = mant_q >> 1;
          exp_d    = exp_q + EXP_ONE;
          sticky_d = sticky_q | mant_q[0];
          cnt_d    = cnt_q + CW'(1);
        end else if ((cnt_q != STEP_LIMIT) && !mant_q[2*mant_bits] && (exp_q > EXP_ONE)) begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - EXP_ONE;
          cnt_d  = cnt_q + CW'(1);
        end else begin
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        if (flush)
          out_d = pack(sign_q, '0, '0);
        else if (exp_r >= EXP_MAX)
          out_d = pack(sign_q, '1, '0);
        else if (!lead_r || (exp_r < EXP_ONE))
          out_d = pack(sign_q, '0, rne_frac);
        else
          out_d = pack(sign_q, exp_r[expo_bits-1:0], rne_frac);
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset discards any in-flight operation and clears the visible result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
    end
  end

  assign in_ready = (state_q == ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign out      = out_q;

endmodule

// File: tb/tb_fp_round_pack.sv
// Directed vector table plus hand sequences for fp_round_pack (binary32).
// Expected subnormal results follow FP_SUBNORMAL_EN.
module tb_fp_round_pack;

  localparam int X = 32;
  localparam int E = 8;
  localparam int M = 23;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic           in_sign;
  logic [E+1:0]   in_exp;
  logic [2*M+1:0] in_mant;
  logic           in_special;
  logic [X-1:0]   in_special_val;
  logic [X-1:0]   out;
  logic           done;
  logic           out_ready;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string          name;
    logic           sign;
    logic [E+1:0]   exp;
    logic [2*M+1:0] mant;
    logic           special;
    logic [X-1:0]   sval;
    logic [X-1:0]   want_out;
    int             want_lat;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  fp_round_pack #(
    .X(X),
    .expo_bits(E),
    .mant_bits(M)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_sign        (in_sign),
    .in_exp         (in_exp),
    .in_mant        (in_mant),
    .in_special     (in_special),
    .in_special_val (in_special_val),
    .out            (out),
    .done           (done),
    .out_ready      (out_ready)
  );

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  function automatic void add_vec(input string n, input logic s, input logic [E+1:0] e,
                                  input logic [2*M+1:0] m, input logic sp,
                                  input logic [X-1:0] sv, input logic [X-1:0] w,
                                  input int l);
    vec_t v;
    v.name = n; v.sign = s; v.exp = e; v.mant = m;
    v.special = sp; v.sval = sv; v.want_out = w; v.want_lat = l;
    vecs.push_back(v);
  endfunction

  // Accept one operand set, then count cycles until done (bounded).
  task automatic apply_stimulus(input vec_t v, output int lat);
    @(negedge clk);
    in_sign        = v.sign;
    in_exp         = v.exp;
    in_mant        = v.mant;
    in_special     = v.special;
    in_special_val = v.sval;
    in_valid       = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 100 && lat < 0; c++) begin
      @(posedge clk);
      #1;
      if (done) lat = c;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   lat;
    vec_t v;
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
    in_special = 1'b0; in_special_val = '0; out_ready = 1'b0;

    add_vec("rshift",      0, 10'd127, 48'h900000000000, 0, 0, 32'h40100000, 3);
    add_vec("tie_even",    0, 10'd127, 48'h400000400000, 0, 0, 32'h3F800000, 2);
    add_vec("tie_odd",     0, 10'd127, 48'h400000C00000, 0, 0, 32'h3F800002, 2);
    add_vec("ovf_pos",     0, 10'd254, 48'h800000000000, 0, 0, 32'h7F800000, 3);
    add_vec("ovf_neg",     1, 10'd254, 48'h800000000000, 0, 0, 32'hFF800000, 3);
    add_vec("special",     0, 10'd0,   48'h0,            1, 32'h7FC00000, 32'h7FC00000, 1);
    add_vec("zero_neg",    1, 10'd50,  48'h0,            0, 0, 32'h80000000, 1);
    add_vec("lshift2",     0, 10'd130, 48'h100000000000, 0, 0, 32'h40000000, 4);
    add_vec("above_half",  0, 10'd127, 48'h400000400001, 0, 0, 32'h3F800001, 2);
    add_vec("carry_out",   0, 10'd127, 48'h7FFFFFC00000, 0, 0, 32'h40000000, 2);
    add_vec("shift_stky",  0, 10'd127, 48'h800000800001, 0, 0, 32'h40000001, 3);
    add_vec("round_ovf",   0, 10'd254, 48'h7FFFFFC00000, 0, 0, 32'h7F800000, 2);
`ifdef FP_SUBNORMAL_EN
    add_vec("sub_exp0",    0, 10'd0,   48'h400000000000, 0, 0, 32'h00400000, 3);
    add_vec("sub_exp1",    0, 10'd1,   48'h200000000000, 0, 0, 32'h00400000, 2);
    add_vec("sub_carry",   0, 10'd1,   48'h3FFFFFC00000, 0, 0, 32'h00800000, 2);
    add_vec("lshift_stop", 0, 10'd3,   48'h080000000000, 0, 0, 32'h00400000, 4);
    add_vec("neg_exp",     0, 10'h3FE, 48'h400000000000, 0, 0, 32'h00100000, 5);
`else
    add_vec("sub_exp0",    0, 10'd0,   48'h400000000000, 0, 0, 32'h00000000, 2);
    add_vec("sub_exp1",    0, 10'd1,   48'h200000000000, 0, 0, 32'h00000000, 2);
    add_vec("sub_carry",   0, 10'd1,   48'h3FFFFFC00000, 0, 0, 32'h00000000, 2);
    add_vec("lshift_stop", 0, 10'd3,   48'h080000000000, 0, 0, 32'h00000000, 4);
    add_vec("neg_exp",     0, 10'h3FE, 48'h400000000000, 0, 0, 32'h00000000, 2);
`endif

    repeat (2) @(posedge clk);
    #1;
    check_output("reset_in_ready", in_ready, 1);
    check_output("reset_done", done, 0);
    check_output("reset_out", out, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i], lat);
      check_output({vecs[i].name, "_out"}, out, vecs[i].want_out);
      check_output({vecs[i].name, "_lat"}, lat, vecs[i].want_lat);
      release_out();
    end
    check_output("back_to_idle", in_ready, 1);

    // Special result held while downstream stalls; new requests are ignored.
    v.name = "hold"; v.sign = 0; v.exp = '0; v.mant = '0; v.special = 1;
    v.sval = 32'h7FC00000; v.want_out = 32'h7FC00000; v.want_lat = 1;
    apply_stimulus(v, lat);
    check_output("hold_out", out, 32'h7FC00000);
    check_output("hold_lat", lat, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_special = 1'b1; in_special_val = 32'h12345678;
      @(posedge clk);
      #1;
      check_output("hold_done", done, 1);
      check_output("hold_stable", out, 32'h7FC00000);
      check_output("hold_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0; in_special = 1'b0;
    release_out();
    check_output("release_in_ready", in_ready, 1);
    check_output("release_done", done, 0);

    // Reset in the middle of a long normalisation.
    @(negedge clk);
    in_sign = 0; in_exp = 10'd100; in_mant = 48'h1; in_special = 0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("norm_busy", in_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("rst_norm_in_ready", in_ready, 1);
    check_output("rst_norm_done", done, 0);
    check_output("rst_norm_out", out, 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset wins over a simultaneous request.
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_special = 1'b1; in_special_val = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; in_special = 1'b0;
    @(posedge clk);
    #1;
    check_output("rst_prio_done", done, 0);
    check_output("rst_prio_in_ready", in_ready, 1);

    // Normal operation resumes after reset.
    v.name = "recover"; v.sign = 0; v.exp = 10'd127; v.mant = 48'h400000400000;
    v.special = 0; v.sval = '0; v.want_out = 32'h3F800000; v.want_lat = 2;
    apply_stimulus(v, lat);
    check_output("recover_out", out, v.want_out);
    check_output("recover_lat", lat, v.want_lat);
    release_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
